my_scan_ctrl: RTL and testbench
===============================

MY_SCAN_CTRL -- requirements
Module: my_scan_ctrl

Interface
REQ-001 The block SHALL have parameter LEN, default 16, meaning scan chain length in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state is updated on the rising edge.
REQ-003 The block SHALL have port reset, input, 1, system reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request to run one shift/capture sequence.
REQ-005 The block SHALL have port abort, input, 1, terminate the current sequence.
REQ-006 The block SHALL have port capture_en, input, 1, insert a capture cycle after the shift; sampled with start.
REQ-007 The block SHALL have port pattern_in, input, LEN, stimulus pattern; sampled with start.
REQ-008 The block SHALL have port chain_so, input, 1, chain serial output, fed from the register scan_out0.
REQ-009 The block SHALL have port chain_si, output, 1, chain serial input, driving the register scan_in0.
REQ-010 The block SHALL have port chain_se, output, 1, chain scan enable, driving the register scan_en.
REQ-011 The block SHALL have port chain_tm, output, 1, chain test mode select, driving the register test_mode.
REQ-012 The block SHALL have port busy, output, 1, sequence in progress.
REQ-013 The block SHALL have port done, output, 1, single-cycle completion pulse.
REQ-014 The block SHALL have port response_out, output, LEN, bits unloaded from the chain.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SHIFT, CAPTURE and DONE.
REQ-016 In IDLE with start=1 and abort=0, the block SHALL latch pattern_in into shift register sreg, latch capture_en into cap_q, clear bit counter cnt, and enter SHIFT on the next edge.
REQ-017 In SHIFT, chain_se SHALL be 1 and chain_si SHALL be sreg[0], both driven from registers or from state and sreg only (no combinational path from inputs).
REQ-018 On each SHIFT edge, the block SHALL update sreg <= {chain_so, sreg[LEN-1:1]} and increment cnt.
REQ-019 When cnt=LEN-1 in SHIFT, the next state SHALL be CAPTURE if cap_q=1, else DONE; SHIFT SHALL therefore last exactly LEN cycles.
REQ-020 After the shift completes, response bit k SHALL equal the k-th chain_so sample, starting from k=0.
REQ-021 CAPTURE SHALL last exactly one cycle, with chain_se=0 and chain_tm=1, and SHALL then enter DONE.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle, response_out SHALL be loaded from sreg on entry to DONE, and the next state SHALL be IDLE.
REQ-023 chain_tm SHALL be 1 in SHIFT, CAPTURE and DONE, and 0 in IDLE.
REQ-024 chain_se SHALL be 0 in all states except SHIFT.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 start SHALL be ignored outside IDLE, and a sequence SHALL never be queued.
REQ-027 abort=1 in any state SHALL force IDLE on the next edge: no done pulse, response_out unchanged, chain_se and chain_tm low from that edge onward.
REQ-028 If start and abort are both 1 in IDLE, abort SHALL win and no sequence SHALL start.
REQ-029 start held high continuously SHALL launch back-to-back sequences, the next one accepted in the first IDLE cycle after DONE.
REQ-030 cnt SHALL be clog2(LEN) bits wide and SHALL never exceed LEN-1.

Reset
REQ-031 While reset=0, the state SHALL be IDLE, and sreg, cnt, cap_q and response_out SHALL be 0.
REQ-032 While reset=0, chain_si, chain_se, chain_tm, busy and done SHALL be 0.
REQ-033 Reset asserted mid-sequence SHALL take effect immediately (asynchronously), with no done pulse.
REQ-034 After reset deasserts, the block SHALL accept start from the first edge following deassertion.

Verification
REQ-035 Bench 1: LEN=16, chain model preloaded 0xA5C3, pattern_in=0x1234, capture_en=0, start for 1 cycle -> chain_se=1 for exactly 16 cycles; chain_si serialises 0x1234 LSB first; done pulses 17 cycles after start; response_out=0xA5C3; chain now holds 0x1234.
REQ-036 Bench 2: same as bench 1 with capture_en=1 -> one cycle with chain_se=0 and chain_tm=1 after the shift; done pulses 18 cycles after start.
REQ-037 Bench 3: abort at the 8th SHIFT cycle -> IDLE next cycle, busy=0, no done pulse, response_out keeps its prior value, chain_se=0.
REQ-038 Bench 4: start and abort both high in IDLE -> busy stays 0 and chain_tm stays 0; start pulsed again during SHIFT -> ignored, exactly one done pulse.
REQ-039 Bench 5: reset asserted during CAPTURE -> all outputs 0 immediately; release, then start with 0xFFFF -> normal 16-cycle shift.
REQ-040 Bench 6: start held high across two sequences -> two done pulses separated by exactly one IDLE cycle plus the sequence length.

Source files
------------

// File: rtl/my_scan_ctrl.sv
// rtl/my_scan_ctrl.sv - scan chain shift/capture sequencer
//
// Loads a stimulus pattern and shifts it LSB first into an external scan
// chain. At the same time it unloads the chain's previous contents into
// response_out. An optional single capture cycle can follow the shift.
//
// Ports:
//   clk          rising-edge system clock
//   reset        asynchronous active-low reset
//   start        request one sequence (honoured in IDLE only)
//   abort        return to IDLE on the next edge, from any state
//   capture_en   add a capture cycle after the shift (sampled with start)
//   pattern_in   stimulus pattern (sampled with start)
//   chain_so     serial data returning from the chain
//   chain_si     serial data into the chain
//   chain_se     chain scan enable
//   chain_tm     chain test mode select
//   busy         sequence in progress
//   done         one-cycle completion pulse
//   response_out bits unloaded from the chain; bit k is the k-th sample
module my_scan_ctrl #(
    parameter int LEN = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic           capture_en,
    input  logic [LEN-1:0] pattern_in,
    input  logic           chain_so,
    output logic           chain_si,
    output logic           chain_se,
    output logic           chain_tm,
    output logic           busy,
    output logic           done,
    output logic [LEN-1:0] response_out
);

    localparam int CW = $clog2(LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        DONE
    } state_t;

    state_t         state_q;
    logic [LEN-1:0] sreg_q;
    logic [LEN-1:0] sreg_d;
    logic [CW-1:0]  cnt_q;
    logic           cap_q;
    logic [LEN-1:0] resp_q;
    logic           se_q;
    logic           tm_q;
    logic           busy_q;
    logic           done_q;

    // The returning bit enters at the top. After LEN shifts the first sample
    // has reached bit 0.
    assign sreg_d = {chain_so, sreg_q[LEN-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            cap_q   <= 1'b0;
            resp_q  <= '0;
            se_q    <= 1'b0;
            tm_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                // Abort wins over everything, including a start in IDLE.
                state_q <= IDLE;
                se_q    <= 1'b0;
                tm_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            sreg_q  <= pattern_in;
                            cap_q   <= capture_en;
                            cnt_q   <= '0;
                            state_q <= SHIFT;
                            se_q    <= 1'b1;
                            tm_q    <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        sreg_q <= sreg_d;
                        if (cnt_q == CNT_LAST) begin
                            // Return to zero rather than wrap, so cnt stays
                            // within 0..LEN-1 for any LEN.
                            cnt_q <= '0;
                            se_q  <= 1'b0;
                            if (cap_q) begin
                                state_q <= CAPTURE;
                            end else begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                resp_q  <= sreg_d;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    CAPTURE: begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        resp_q  <= sreg_q;
                    end
                    DONE: begin
                        state_q <= IDLE;
                        tm_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        se_q    <= 1'b0;
                        tm_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // se_q is high only in SHIFT, so chain_si comes from registers alone.
    assign chain_si     = se_q & sreg_q[0];
    assign chain_se     = se_q;
    assign chain_tm     = tm_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign response_out = resp_q;

endmodule

// File: tb/tb_my_scan_ctrl.sv
// tb/tb_my_scan_ctrl.sv - self-checking bench for my_scan_ctrl
module tb_my_scan_ctrl;

    localparam int LEN = 16;

    logic           clk;
    logic           reset;
    logic           start;
    logic           abort;
    logic           capture_en;
    logic [LEN-1:0] pattern_in;
    logic           chain_so;
    logic           chain_si;
    logic           chain_se;
    logic           chain_tm;
    logic           busy;
    logic           done;
    logic [LEN-1:0] response_out;

    my_scan_ctrl #(.LEN(LEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .capture_en   (capture_en),
        .pattern_in   (pattern_in),
        .chain_so     (chain_so),
        .chain_si     (chain_si),
        .chain_se     (chain_se),
        .chain_tm     (chain_tm),
        .busy         (busy),
        .done         (done),
        .response_out (response_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External chain: shifts toward bit 0 when enabled, inverts on capture.
    logic [LEN-1:0] chain;
    assign chain_so = chain[0];

    int tests = 0;
    int fails = 0;

    // Reference model: position within the current sequence (0 = idle).
    int             m_phase = 0;
    int             m_total = 0;
    logic [LEN-1:0] m_pat   = '0;
    logic [LEN-1:0] m_pend  = '0;
    logic [LEN-1:0] m_resp  = '0;

    int cyc = 0;
    int acc_cyc = 0;
    int done_cyc = 0;
    int prev_done_cyc = 0;
    int done_cnt = 0;
    int se_cnt = 0;
    int cap_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Called at a falling edge: check outputs, drive inputs, advance one clock.
    task automatic step(input logic st, input logic ab, input logic ce, input logic [LEN-1:0] pat);
        logic e_busy, e_se, e_done, e_si;
        logic s_se, s_si, s_cap;
        e_busy = (m_phase > 0);
        e_se   = (m_phase >= 1) && (m_phase <= LEN);
        e_done = (m_phase > 0) && (m_phase == m_total);
        e_si   = 1'b0;
        if (e_se) e_si = m_pat[m_phase-1];
        check("busy", 64'(busy), 64'(e_busy));
        check("chain_tm", 64'(chain_tm), 64'(e_busy));
        check("chain_se", 64'(chain_se), 64'(e_se));
        check("done", 64'(done), 64'(e_done));
        check("chain_si", 64'(chain_si), 64'(e_si));
        check("response_out", 64'(response_out), 64'(m_resp));
        if (chain_se) se_cnt++;
        if (chain_tm && !chain_se && busy && !done) cap_cnt++;
        if (done) begin
            done_cnt++;
            prev_done_cyc = done_cyc;
            done_cyc = cyc;
        end
        s_se  = chain_se;
        s_si  = chain_si;
        s_cap = chain_tm && !chain_se && busy && !done;

        start      = st;
        abort      = ab;
        capture_en = ce;
        pattern_in = pat;
        @(posedge clk);
        if (ab) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (st) begin
                m_phase = 1;
                m_pat   = pat;
                m_total = LEN + 1 + int'(ce);
                m_pend  = chain;
                acc_cyc = cyc;
            end
        end else if (m_phase == m_total) begin
            m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase == m_total) m_resp = m_pend;
        end
        #1;
        if (s_se) chain = {s_si, chain[LEN-1:1]};
        else if (s_cap) chain = ~chain;
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, LEN'($urandom));
    endtask

    task automatic clear_stats();
        se_cnt = 0;
        cap_cnt = 0;
        done_cnt = 0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        capture_en = 1'b0;
        pattern_in = '0;
        chain = '0;
        repeat (2) @(negedge clk);
        check("rst_outs", 64'({chain_si, chain_se, chain_tm, busy, done}), 64'd0);
        check("rst_resp", 64'(response_out), 64'd0);
        reset = 1'b1;

        // Bench 1: plain shift
        chain = 16'hA5C3;
        clear_stats();
        step(1'b1, 1'b0, 1'b0, 16'h1234);
        idle(19);
        check("b1_se_cycles", 64'(se_cnt), 64'd16);
        check("b1_done_cnt", 64'(done_cnt), 64'd1);
        check("b1_done_lat", 64'(done_cyc - acc_cyc), 64'd17);
        check("b1_resp", 64'(response_out), 64'hA5C3);
        check("b1_chain", 64'(chain), 64'h1234);

        // Bench 2: shift plus capture
        chain = 16'hA5C3;
        clear_stats();
        step(1'b1, 1'b0, 1'b1, 16'h1234);
        idle(20);
        check("b2_se_cycles", 64'(se_cnt), 64'd16);
        check("b2_cap_cycles", 64'(cap_cnt), 64'd1);
        check("b2_done_lat", 64'(done_cyc - acc_cyc), 64'd18);
        check("b2_resp", 64'(response_out), 64'hA5C3);

        // Bench 3: abort at the 8th shift cycle
        chain = 16'h0F0F;
        clear_stats();
        step(1'b1, 1'b0, 1'b0, 16'hBEEF);
        for (int i = 0; i < 40 && m_phase != 8; i++) idle(1);
        check("b3_reached_shift8", 64'(m_phase), 64'd8);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        check("b3_busy", 64'(busy), 64'd0);
        check("b3_se", 64'(chain_se), 64'd0);
        check("b3_resp_kept", 64'(response_out), 64'hA5C3);
        idle(20);
        check("b3_no_done", 64'(done_cnt), 64'd0);

        // Bench 4: start+abort together, then start during shift
        clear_stats();
        step(1'b1, 1'b1, 1'b0, 16'h5555);
        check("b4_busy", 64'(busy), 64'd0);
        check("b4_tm", 64'(chain_tm), 64'd0);
        step(1'b1, 1'b0, 1'b0, 16'h00FF);
        idle(4);
        step(1'b1, 1'b0, 1'b1, 16'hFFFF);
        idle(25);
        check("b4_one_done", 64'(done_cnt), 64'd1);

        // Bench 5: reset during capture, then a fresh sequence
        clear_stats();
        step(1'b1, 1'b0, 1'b1, 16'h3C3C);
        for (int i = 0; i < 40 && m_phase != LEN + 1; i++) idle(1);
        check("b5_in_capture", 64'({chain_tm, chain_se}), 64'b10);
        #2 reset = 1'b0;
        #1;
        check("b5_rst_outs", 64'({chain_si, chain_se, chain_tm, busy, done}), 64'd0);
        check("b5_rst_resp", 64'(response_out), 64'd0);
        m_phase = 0;
        m_resp = '0;
        @(negedge clk);
        reset = 1'b1;
        clear_stats();
        chain = 16'h1357;
        step(1'b1, 1'b0, 1'b0, 16'hFFFF);
        idle(19);
        check("b5_se_cycles", 64'(se_cnt), 64'd16);
        check("b5_done_cnt", 64'(done_cnt), 64'd1);
        check("b5_chain", 64'(chain), 64'hFFFF);

        // Bench 6: start held across two sequences
        clear_stats();
        for (int i = 0; i < 60 && done_cnt < 2; i++) step(1'b1, 1'b0, 1'b0, 16'h9A9A);
        check("b6_two_dones", 64'(done_cnt), 64'd2);
        check("b6_spacing", 64'(done_cyc - prev_done_cyc), 64'd18);
        idle(20);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (m_phase == 0 && ($urandom % 3) == 0) chain = LEN'($urandom);
            step(($urandom % 4) == 0, ($urandom % 50) == 0, 1'($urandom),
                 LEN'($urandom));
        end
        idle(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
